// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced key pulses into click, double click, long press and auto-repeat
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   keyPress     one-cycle pulse, debounced press
//   keyRelease   one-cycle pulse, debounced release
//   click        one-cycle pulse, single click
//   doubleClick  one-cycle pulse, double click
//   longPress    one-cycle pulse, hold reached LONG_CYCLES
//   repeatTick   one-cycle pulse, periodic while long-held
//   held         level, key currently considered down
module key_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 15_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic keyPress,
    input  logic keyRelease,
    output logic click,
    output logic doubleClick,
    output logic longPress,
    output logic repeatTick,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED1  = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESSED2  = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             click_nxt;
    logic             double_click_nxt;
    logic             long_press_nxt;
    logic             repeat_tick_nxt;
    logic             held_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            click       <= 1'b0;
            doubleClick <= 1'b0;
            longPress   <= 1'b0;
            repeatTick  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            click       <= click_nxt;
            doubleClick <= double_click_nxt;
            longPress   <= long_press_nxt;
            repeatTick  <= repeat_tick_nxt;
            held        <= held_nxt;
        end
    end

    // The press/release pulse cycle itself is the first elapsed cycle of the
    // hold and gap windows, so entering PRESSED1 or WAIT_GAP loads the timer
    // with 1. This puts longPress at T_press+LONG_CYCLES and click at
    // T_release+GAP_CYCLES once the registered output delay is included.
    // LONG_HOLD is entered one cycle after its terminal count and starts at 0.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        click_nxt        = 1'b0;
        double_click_nxt = 1'b0;
        long_press_nxt   = 1'b0;
        repeat_tick_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (keyPress) begin
                    state_nxt = PRESSED1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESSED1: begin
                // A release on the terminal cycle beats the long-press timeout.
                if (keyRelease) begin
                    state_nxt = WAIT_GAP;
                    cnt_nxt   = CNT_ONE;
                end else if (cnt == LONG_TERM) begin
                    long_press_nxt = 1'b1;
                    state_nxt      = LONG_HOLD;
                    cnt_nxt        = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            WAIT_GAP: begin
                // A press on the terminal cycle beats the click timeout.
                if (keyPress) begin
                    state_nxt = PRESSED2;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_TERM) begin
                    click_nxt = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED2: begin
                // No timeout: a long second hold still ends as a double click.
                cnt_nxt = '0;
                if (keyRelease) begin
                    double_click_nxt = 1'b1;
                    state_nxt        = IDLE;
                end
            end
            LONG_HOLD: begin
                if (keyRelease) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == REPEAT_TERM) begin
                    repeat_tick_nxt = 1'b1;
                    cnt_nxt         = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        held_nxt = (state_nxt == PRESSED1) || (state_nxt == PRESSED2) ||
                   (state_nxt == LONG_HOLD);
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard bench for key_event_decoder with a timestamp-based reference model
module tb_key_event_decoder;

    localparam int L = 20;
    localparam int G = 8;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_press = 1'b0;
    logic key_release = 1'b0;
    logic click, double_click, long_press, repeat_tick, held;

    key_event_decoder #(
        .LONG_CYCLES  (L),
        .GAP_CYCLES   (G),
        .REPEAT_CYCLES(R),
        .CNT_W        (30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keyPress   (key_press),
        .keyRelease (key_release),
        .click      (click),
        .doubleClick(double_click),
        .longPress  (long_press),
        .repeatTick (repeat_tick),
        .held       (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] o;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // Reference model: gesture phase plus the absolute cycle of the pulse that
    // opened the current window. Deadlines are pulse time + window length.
    localparam int M_IDLE = 0, M_DOWN1 = 1, M_GAP = 2, M_DOWN2 = 3, M_LONG = 4;
    int m_mode = M_IDLE;
    int t_mark = 0;
    bit m_valid = 1'b0;

    // Consumes the inputs of cycle c; returns {click,dbl,long,rep,held} for c+1.
    task automatic model_step(input bit p, input bit r, input bit rs, input int c,
                              output logic [4:0] o);
        bit ck, db, lp, rp;
        ck = 0; db = 0; lp = 0; rp = 0;
        if (rs) begin
            m_mode  = M_IDLE;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: if (p) begin m_mode = M_DOWN1; t_mark = c; end
                M_DOWN1: begin
                    if (r) begin
                        m_mode = M_GAP; t_mark = c;
                    end else if (c - t_mark == L - 1) begin
                        lp = 1; m_mode = M_LONG; t_mark = c + 1;
                    end
                end
                M_GAP: begin
                    if (p) m_mode = M_DOWN2;
                    else if (c - t_mark == G - 1) begin ck = 1; m_mode = M_IDLE; end
                end
                M_DOWN2: if (r) begin db = 1; m_mode = M_IDLE; end
                default: begin
                    if (r) m_mode = M_IDLE;
                    else if ((c + 1 - t_mark) % R == 0) rp = 1;
                end
            endcase
        end
        o = {ck, db, lp, rp,
             (m_mode == M_DOWN1 || m_mode == M_DOWN2 || m_mode == M_LONG)};
    endtask

    task automatic tick(input bit p, input bit r, input bit rs);
        logic [4:0] o;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        key_press   = p;
        key_release = r;
        rst         = rs;
        model_step(p, r, rs, cyc, o);
        if (m_valid) begin
            e.cyc = cyc + 1;
            e.o   = o;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard entry for this cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [4:0] got;
            e   = q.pop_front();
            got = {click, double_click, long_press, repeat_tick, held};
            tests++;
            if (e.cyc != cyc || got !== e.o) begin
                fails++;
                $display("FAIL outputs cycle %0d (entry %0d) {click,dbl,long,rep,held} got %b expected %b",
                         cyc, e.cyc, got, e.o);
            end
        end
    end

    initial begin
        tick(0, 0, 1);
        tick(0, 0, 1);
        idle(3);

        // single click
        tick(1, 0, 0); idle(3); tick(0, 1, 0); idle(15);
        // double click
        tick(1, 0, 0); idle(3); tick(0, 1, 0); idle(3); tick(1, 0, 0); idle(6);
        tick(0, 1, 0); idle(10);
        // long press with repeat, release coincides with a repeat tick
        tick(1, 0, 0); idle(39); tick(0, 1, 0); idle(10);
        // release on the long-press terminal cycle
        tick(1, 0, 0); idle(18); tick(0, 1, 0); idle(12);
        // press on the gap terminal cycle
        tick(1, 0, 0); idle(3); tick(0, 1, 0); idle(6); tick(1, 0, 0); idle(1);
        tick(0, 1, 0); idle(10);
        // reset mid-gesture, then a normal click
        tick(1, 0, 0); idle(4); tick(0, 0, 1); idle(2); tick(0, 1, 0); idle(11);
        tick(1, 0, 0); idle(1); tick(0, 1, 0); idle(12);
        // simultaneous press and release in idle and while pressed
        tick(1, 1, 0); idle(2); tick(1, 1, 0); idle(12);

        // randomized gestures: gaps and holds straddle the window boundaries
        for (int g = 0; g < 90; g++) begin
            int hold;
            idle($urandom_range(0, 12));
            tick(1, ($urandom_range(0, 9) == 0), 0);
            hold = $urandom_range(0, 45);
            for (int k = 0; k < hold; k++)
                tick(($urandom_range(0, 19) == 0), 1'b0, ($urandom_range(0, 149) == 0));
            tick(($urandom_range(0, 5) == 0), 1'b1, 1'b0);
        end
        idle(40);

        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending entries expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
